// File: rtl/key_scheduler_multimode_sequential_pkg.sv
// Shared definitions for the multimode AES key scheduler: mode encodings,
// per-mode schedule lengths, the S-box and the round constants.
package key_scheduler_multimode_sequential_pkg;

  localparam int NB_WORD      = 32;
  localparam int N_BYTES_WORD = 4;

  typedef enum logic [1:0] {
    KEY_MODE_AES128 = 2'd0,
    KEY_MODE_AES192 = 2'd1,
    KEY_MODE_AES256 = 2'd2,
    KEY_MODE_RSVD   = 2'd3
  } key_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_READY
  } sched_state_e;

  // Key length in words for a mode; zero for the reserved encoding.
  function automatic logic [5:0] mode_nk(input logic [1:0] mode);
    case (mode)
      KEY_MODE_AES128: return 6'd4;
      KEY_MODE_AES192: return 6'd6;
      KEY_MODE_AES256: return 6'd8;
      default:         return 6'd0;
    endcase
  endfunction

  // Number of rounds for a mode; zero for the reserved encoding.
  function automatic logic [5:0] mode_nr(input logic [1:0] mode);
    case (mode)
      KEY_MODE_AES128: return 6'd10;
      KEY_MODE_AES192: return 6'd12;
      KEY_MODE_AES256: return 6'd14;
      default:         return 6'd0;
    endcase
  endfunction

  // Total expanded words, four per round key including round 0.
  function automatic logic [5:0] mode_ntot(input logic [1:0] mode);
    return (mode == KEY_MODE_RSVD) ? 6'd0 : 6'((mode_nr(mode) + 6'd1) << 2);
  endfunction

  // GF(2^8) multiply with the AES reduction polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, which maps 0 to 0) followed by
  // the affine transform; avoids a 256-entry table in the source.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [NB_WORD-1:0] sub_word(input logic [NB_WORD-1:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round constants indexed by i/Nk (1..10).
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/key_scheduler_multimode_sequential_step.sv
// Combinational generation of one expanded key word w[i] from w[i-1],
// w[i-Nk], the word index and the key mode.
module key_expand_word_step
  import key_scheduler_multimode_sequential_pkg::*;
(
  input  logic [NB_WORD-1:0] w_prev,
  input  logic [NB_WORD-1:0] w_back,
  input  logic [5:0]         word_idx,
  input  logic [1:0]         key_mode,
  output logic [NB_WORD-1:0] w_next
);

  logic             rot_sel;
  logic             sub_sel;
  logic [3:0]       rcon_idx;
  logic [NB_WORD-1:0] temp;

  // Decode where this index sits within its Nk-word group.
  always_comb begin
    rot_sel  = 1'b0;
    sub_sel  = 1'b0;
    rcon_idx = 4'd0;
    case (key_mode)
      KEY_MODE_AES128: begin
        rot_sel  = (word_idx[1:0] == 2'd0);
        rcon_idx = word_idx[5:2];
      end
      KEY_MODE_AES192: begin
        rot_sel  = ((word_idx % 6'd6) == 6'd0);
        rcon_idx = 4'(word_idx / 6'd6);
      end
      KEY_MODE_AES256: begin
        rot_sel  = (word_idx[2:0] == 3'd0);
        sub_sel  = (word_idx[2:0] == 3'd4);
        rcon_idx = {1'b0, word_idx[5:3]};
      end
      default: ;
    endcase
  end

  // Apply RotWord/SubWord/Rcon as selected and fold in w[i-Nk].
  always_comb begin
    temp = w_prev;
    if (rot_sel)
      temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon(rcon_idx), 24'h0};
    else if (sub_sel)
      temp = sub_word(w_prev);
    w_next = w_back ^ temp;
  end

endmodule

// File: rtl/key_scheduler_multimode_sequential.sv
// Sequential AES-128/192/256 key expander. Produces N_WORDS_PER_CLK words
// per enabled clock into a 60-word register file exposed as round keys.
module key_scheduler_multimode_sequential
  import key_scheduler_multimode_sequential_pkg::*;
#(
  parameter int NB_BYTE         = 8,
  parameter int N_BYTES_STATE   = 16,
  parameter int N_BYTES_KEY_MAX = 32,
  parameter int N_ROUNDS_MAX    = 14,
  parameter int N_WORDS_PER_CLK = 1
) (
  input  logic                                           i_clock,
  input  logic                                           i_reset,
  input  logic                                           i_valid,
  input  logic                                           i_trigger_schedule,
  input  logic [1:0]                                     i_key_mode,
  input  logic [N_BYTES_KEY_MAX*NB_BYTE-1:0]             i_key,
  output logic [N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)-1:0] o_round_key_vector,
  output logic                                           o_busy,
  output logic                                           o_done,
  output logic                                           o_keys_ready,
  output logic                                           o_key_error
);

  localparam int NB_KEY        = N_BYTES_KEY_MAX * NB_BYTE;
  localparam int NB_STATE      = N_BYTES_STATE * NB_BYTE;
  localparam int N_WORDS_STATE = N_BYTES_STATE / N_BYTES_WORD;
  localparam int N_WORDS_TOTAL = N_WORDS_STATE * (N_ROUNDS_MAX + 1);
  localparam int N_KEY_WORDS   = N_BYTES_KEY_MAX / N_BYTES_WORD;

  logic [NB_WORD-1:0] w_q [N_WORDS_TOTAL];
  logic [NB_WORD-1:0] w_rd [64];
  logic [NB_WORD-1:0] key_words [N_KEY_WORDS];
  logic [NB_WORD-1:0] step_out [N_WORDS_PER_CLK];
  logic [5:0]         step_idx [N_WORDS_PER_CLK];

  sched_state_e state;
  key_mode_e    mode_q;
  logic [5:0]   word_cnt;
  logic [5:0]   nk;
  logic [5:0]   ntot;
  logic [5:0]   words_left;
  logic [5:0]   n_step;
  logic [5:0]   cnt_next;
  logic         trig_start;
  logic         trig_bad;
  logic         gen_adv;

  assign nk         = mode_nk(mode_q);
  assign ntot       = mode_ntot(mode_q);
  assign words_left = ntot - word_cnt;
  assign n_step     = (words_left < 6'(N_WORDS_PER_CLK)) ? words_left : 6'(N_WORDS_PER_CLK);
  assign cnt_next   = word_cnt + n_step;

  // A reserved-mode trigger only raises the error pulse; it never restarts.
  assign trig_start = i_valid & i_trigger_schedule & (i_key_mode != KEY_MODE_RSVD);
  assign trig_bad   = i_valid & i_trigger_schedule & (i_key_mode == KEY_MODE_RSVD);
  assign gen_adv    = i_valid & (state == ST_GEN) & ~trig_start;

  for (genvar k = 0; k < N_KEY_WORDS; k++) begin : g_key
    assign key_words[k] = i_key[NB_KEY-1-k*NB_WORD -: NB_WORD];
  end

  // Pad the read port to 64 entries so any 6-bit index is safe.
  for (genvar k = 0; k < 64; k++) begin : g_rd
    if (k < N_WORDS_TOTAL) begin : g_live
      assign w_rd[k] = w_q[k];
    end else begin : g_pad
      assign w_rd[k] = '0;
    end
  end

  // Chain of word generators; word j uses word j-1 of the same cycle.
  for (genvar j = 0; j < N_WORDS_PER_CLK; j++) begin : g_step
    logic [NB_WORD-1:0] prev;
    logic [NB_WORD-1:0] nxt;
    assign step_idx[j] = word_cnt + 6'(j);
    if (j == 0) begin : g_head
      assign prev = w_rd[word_cnt - 6'd1];
    end else begin : g_link
      assign prev = g_step[j-1].nxt;
    end
    key_expand_word_step u_step (
      .w_prev   (prev),
      .w_back   (w_rd[step_idx[j] - nk]),
      .word_idx (step_idx[j]),
      .key_mode (mode_q),
      .w_next   (nxt)
    );
    assign step_out[j] = nxt;
  end

  // Control FSM: tracks the schedule, counter and registered status flags.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      mode_q       <= KEY_MODE_AES128;
      word_cnt     <= 6'd0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_keys_ready <= 1'b0;
      o_key_error  <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_key_error <= trig_bad;
      if (trig_start) begin
        mode_q       <= key_mode_e'(i_key_mode);
        word_cnt     <= mode_nk(i_key_mode);
        state        <= ST_GEN;
        o_busy       <= 1'b1;
        o_keys_ready <= 1'b0;
      end else if (gen_adv) begin
        word_cnt <= cnt_next;
        if (cnt_next == ntot) begin
          state        <= ST_READY;
          o_busy       <= 1'b0;
          o_done       <= 1'b1;
          o_keys_ready <= 1'b1;
        end
      end
    end
  end

  // Register file: key load on trigger, then the generated words in GEN.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < N_WORDS_TOTAL; k++) w_q[k] <= '0;
    end else if (trig_start) begin
      for (int k = 0; k < N_WORDS_TOTAL; k++) w_q[k] <= '0;
      for (int k = 0; k < N_KEY_WORDS; k++)
        if (6'(k) < mode_nk(i_key_mode)) w_q[k] <= key_words[k];
    end else if (gen_adv) begin
      for (int j = 0; j < N_WORDS_PER_CLK; j++)
        if (6'(j) < n_step) w_q[step_idx[j]] <= step_out[j];
    end
  end

  // Round r occupies [r*128 +: 128] with its first word in the MSBs.
  for (genvar r = 0; r <= N_ROUNDS_MAX; r++) begin : g_round
    for (genvar c = 0; c < N_WORDS_STATE; c++) begin : g_col
      assign o_round_key_vector[r*NB_STATE + (N_WORDS_STATE-1-c)*NB_WORD +: NB_WORD] =
        w_q[r*N_WORDS_STATE + c];
    end
  end

endmodule

// File: tb/tb_key_scheduler_multimode_sequential.sv
// Directed bench: three schedulers (1, 2 and 4 words per clock) share the
// same stimulus; results are compared against FIPS-197 key expansion values.
module tb_key_scheduler_multimode_sequential;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic         i_clock = 1'b0;
  logic         i_reset = 1'b1;
  logic         i_valid = 1'b0;
  logic         i_trigger_schedule = 1'b0;
  logic [1:0]   i_key_mode = 2'd0;
  logic [255:0] i_key = '0;

  logic [1919:0] vec1, vec2, vec4;
  logic busy1, busy2, busy4, done1, done2, done4;
  logic rdy1, rdy2, rdy4, err1, err2, err4;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int done_cnt1 = 0, done_cnt2 = 0, done_cnt4 = 0;
  int done_at1 = 0, done_at2 = 0, done_at4 = 0;

  always #5 i_clock = ~i_clock;

  key_scheduler_multimode_sequential #(.N_WORDS_PER_CLK(1)) dut1 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_trigger_schedule(i_trigger_schedule), .i_key_mode(i_key_mode), .i_key(i_key),
    .o_round_key_vector(vec1), .o_busy(busy1), .o_done(done1),
    .o_keys_ready(rdy1), .o_key_error(err1));

  key_scheduler_multimode_sequential #(.N_WORDS_PER_CLK(2)) dut2 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_trigger_schedule(i_trigger_schedule), .i_key_mode(i_key_mode), .i_key(i_key),
    .o_round_key_vector(vec2), .o_busy(busy2), .o_done(done2),
    .o_keys_ready(rdy2), .o_key_error(err2));

  key_scheduler_multimode_sequential #(.N_WORDS_PER_CLK(4)) dut4 (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid),
    .i_trigger_schedule(i_trigger_schedule), .i_key_mode(i_key_mode), .i_key(i_key),
    .o_round_key_vector(vec4), .o_busy(busy4), .o_done(done4),
    .o_keys_ready(rdy4), .o_key_error(err4));

  function automatic logic [127:0] rk(input logic [1919:0] v, input int r);
    return v[r*128 +: 128];
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic trig,
                               input logic [1:0] mode, input logic [255:0] key);
    i_valid            = valid;
    i_trigger_schedule = trig;
    i_key_mode         = mode;
    i_key              = key;
  endtask

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic clearDone();
    edge_no   = 0;
    done_cnt1 = 0; done_cnt2 = 0; done_cnt4 = 0;
    done_at1  = 0; done_at2  = 0; done_at4  = 0;
  endtask

  task automatic runEdges(input int n);
    for (int e = 0; e < n; e++) begin
      tick();
      edge_no++;
      if (done1) begin done_cnt1++; if (done_at1 == 0) done_at1 = edge_no; end
      if (done2) begin done_cnt2++; if (done_at2 == 0) done_at2 = edge_no; end
      if (done4) begin done_cnt4++; if (done_at4 == 0) done_at4 = edge_no; end
    end
  endtask

  // Trigger edge followed by dropping the trigger; done counters restart.
  task automatic startSchedule(input logic [1:0] mode, input logic [255:0] key);
    applyStimulus(1'b1, 1'b1, mode, key);
    tick();
    applyStimulus(1'b1, 1'b0, mode, key);
    clearDone();
  endtask

  initial begin
    // Reset state
    #12;
    checkOutput("reset_vec_any", 128'(|vec1), 128'd0);
    checkOutput("reset_flags", {124'd0, busy1, done1, rdy1, err1}, 128'd0);
    tick();
    i_reset = 1'b0;
    tick();

    // AES-128, all three widths
    startSchedule(2'd0, K128);
    checkOutput("a128_busy_after_trig", 128'(busy1), 128'd1);
    checkOutput("a128_round0", rk(vec1, 0), 128'h2b7e151628aed2a6abf7158809cf4f3c);
    runEdges(41);
    checkOutput("a128_done_cnt_w1", 128'(done_cnt1), 128'd1);
    checkOutput("a128_done_at_w1", 128'(done_at1), 128'd40);
    checkOutput("a128_done_at_w2", 128'(done_at2), 128'd20);
    checkOutput("a128_done_at_w4", 128'(done_at4), 128'd10);
    checkOutput("a128_done_low", 128'(done1), 128'd0);
    checkOutput("a128_ready_busy", {126'd0, rdy1, busy1}, 128'd2);
    checkOutput("a128_round1", rk(vec1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("a128_round10_w1", rk(vec1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("a128_round10_w4", rk(vec4, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    checkOutput("a128_rounds11_14_zero", 128'(|vec1[1919:1408]), 128'd0);

    // AES-192 from READY
    startSchedule(2'd1, K192);
    runEdges(47);
    checkOutput("a192_done_at_w4", 128'(done_at4), 128'd12);
    checkOutput("a192_done_at_w2", 128'(done_at2), 128'd23);
    checkOutput("a192_done_at_w1", 128'(done_at1), 128'd46);
    checkOutput("a192_round1", rk(vec4, 1), 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    checkOutput("a192_round12_w4", rk(vec4, 12), 128'he98ba06f448c773c8ecc720401002202);
    checkOutput("a192_round12_w1", rk(vec1, 12), 128'he98ba06f448c773c8ecc720401002202);
    checkOutput("a192_rounds13_14_zero", 128'(|vec4[1919:1664]), 128'd0);

    // AES-256
    startSchedule(2'd2, K256);
    runEdges(53);
    checkOutput("a256_done_at_w2", 128'(done_at2), 128'd26);
    checkOutput("a256_done_at_w4", 128'(done_at4), 128'd13);
    checkOutput("a256_done_at_w1", 128'(done_at1), 128'd52);
    checkOutput("a256_round2", rk(vec2, 2), 128'h9ba354118e6925afa51a8b5f2067fcde);
    checkOutput("a256_round14_w2", rk(vec2, 14), 128'hfe4890d1e6188d0b046df344706c631e);
    checkOutput("a256_round14_w1", rk(vec1, 14), 128'hfe4890d1e6188d0b046df344706c631e);

    // Reserved mode while READY
    applyStimulus(1'b1, 1'b1, 2'd3, K128);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, K128);
    checkOutput("rsvd_err_pulse", 128'(err1), 128'd1);
    checkOutput("rsvd_ready_kept", {126'd0, rdy1, busy1}, 128'd2);
    checkOutput("rsvd_round14_kept", rk(vec1, 14), 128'hfe4890d1e6188d0b046df344706c631e);
    checkOutput("rsvd_round0_kept", rk(vec1, 0), 128'h603deb1015ca71be2b73aef0857d7781);
    tick();
    checkOutput("rsvd_err_drop", 128'(err1), 128'd0);

    // Restart at GEN edge 20
    startSchedule(2'd0, K128);
    runEdges(19);
    startSchedule(2'd0, K128);
    checkOutput("restart_ready_low", 128'(rdy1), 128'd0);
    runEdges(41);
    checkOutput("restart_done_cnt", 128'(done_cnt1), 128'd1);
    checkOutput("restart_done_at", 128'(done_at1), 128'd40);

    // Trigger coinciding with the final word wins
    startSchedule(2'd0, K128);
    runEdges(39);
    applyStimulus(1'b1, 1'b1, 2'd0, K128);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, K128);
    checkOutput("final_trig_flags", {125'd0, done1, rdy1, busy1}, 128'd1);

    // Freeze with i_valid low for 5 cycles
    startSchedule(2'd0, K128);
    runEdges(10);
    i_valid = 1'b0;
    runEdges(5);
    checkOutput("freeze_busy", {126'd0, busy1, rdy1}, 128'd2);
    i_valid = 1'b1;
    runEdges(32);
    checkOutput("freeze_done_at", 128'(done_at1), 128'd45);
    checkOutput("freeze_round10", rk(vec1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Asynchronous reset mid-GEN
    startSchedule(2'd2, K256);
    runEdges(15);
    #3;
    i_reset = 1'b1;
    #1;
    checkOutput("areset_vec_any", 128'(|vec1), 128'd0);
    checkOutput("areset_flags", {124'd0, busy1, done1, rdy1, err1}, 128'd0);
    tick();
    i_reset = 1'b0;
    runEdges(3);
    checkOutput("areset_idle", {126'd0, busy1, rdy1}, 128'd0);
    startSchedule(2'd2, K256);
    runEdges(53);
    checkOutput("post_reset_done_at", 128'(done_at1), 128'd52);
    checkOutput("post_reset_round14", rk(vec1, 14), 128'hfe4890d1e6188d0b046df344706c631e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_scheduler_multimode_sequential.md
# key_scheduler_multimode_sequential

Sequential AES key expander supporting AES-128, AES-192 and AES-256, with the key length selected per schedule at run time. It generates a configurable number of expanded words per enabled clock and exposes all round keys as one flat vector with busy, done and ready status. It sits in front of the AES round pipeline used by the GCM datapath and replaces the fixed-AES-256, fixed-rate scheduler.

## Interface
- NB_BYTE, 8, bits per byte; any other value is a bad configuration.
- N_BYTES_STATE, 16, bytes per round key.
- N_BYTES_KEY_MAX, 32, width of the key input in bytes (largest supported key).
- N_ROUNDS_MAX, 14, round count of the largest mode; sets the output vector size.
- N_WORDS_PER_CLK, 1, expanded 32-bit words produced per enabled clock; legal values are 1, 2 and 4.

Ports:
- i_clock  in  1  single clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  clock enable; all state advances only when high.
- i_trigger_schedule  in  1  start (or restart) a schedule; sampled only with i_valid.
- i_key_mode  in  2  selects the mode: 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- i_key  in  N_BYTES_KEY_MAX*NB_BYTE  key, MSB-aligned; AES-128 uses [255:128], AES-192 uses [255:64].
- o_round_key_vector  out  N_BYTES_STATE*NB_BYTE*(N_ROUNDS_MAX+1)  round key r is at [r*128 +: 128]; word w[4r] is in the MSBs.
- o_busy  out  1  expansion in progress.
- o_done  out  1  one-cycle pulse when a schedule completes.
- o_keys_ready  out  1  level; the vector holds a complete schedule for the latched mode.
- o_key_error  out  1  one-cycle pulse when a trigger arrives with the reserved mode.

## Operation
- Mode constants:
  - AES-128: Nk = 4, Nr = 10.
  - AES-192: Nk = 6, Nr = 12.
  - AES-256: Nk = 8, Nr = 14.
  - Total words: Ntot = 4*(Nr+1), giving 44, 52 or 60.
- Storage is a 60-word register file w[0..59]. A 6-bit word counter points at the next word to write.
- Word rule, with temp = w[i-1]:
  - i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
  - Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
  - Then w[i] = w[i-Nk] ^ temp.
  - When N_WORDS_PER_CLK > 1, the words of one cycle are chained combinationally: word j uses word j-1 of the same cycle.
- FSM states: IDLE, GEN, READY.
- Valid trigger with mode 0 to 2, from any state:
  - Latch the mode.
  - Load w[0..Nk-1] from i_key and zero w[Nk..59].
  - Set the counter to Nk, clear o_keys_ready, and go to GEN.
- GEN: on each i_valid, write min(N_WORDS_PER_CLK, Ntot - counter) words and advance the counter by that amount. Words past Ntot are discarded.
- When the counter reaches Ntot: assert o_done for one cycle, set o_keys_ready, go to READY, and hold the vector.
- Trigger with mode 3:
  - No state change; the current schedule and o_keys_ready are unaffected.
  - o_key_error pulses one cycle.
- A trigger in GEN restarts the schedule. The aborted run produces no o_done.
- A trigger in the same cycle as the final word: the trigger wins, with no o_done and no o_keys_ready.
- i_valid low: the FSM, counter and storage freeze. o_done and o_key_error still drop after one cycle.
- Rounds above Nr read as zero.

## Timing
- Reset (asynchronous) values:
  - o_round_key_vector = 0.
  - o_busy = 0, o_done = 0, o_keys_ready = 0, o_key_error = 0.
  - FSM in IDLE, counter = 0.
- Trigger sampled at edge k: w[0..Nk-1] are visible after edge k, and o_busy rises after edge k.
- Completion:
  - C = ceil((Ntot - Nk) / N_WORDS_PER_CLK) enabled edges after k.
  - N_WORDS_PER_CLK = 1: C = 40, 46 and 52 for the three modes.
  - N_WORDS_PER_CLK = 4: C = 10, 12 and 13.
  - At the C-th enabled edge: the last words are written, o_done goes high for one cycle, o_keys_ready goes high, and o_busy goes low.
- While in GEN the vector is partially valid; consumers qualify it with o_keys_ready.
- Reset asserted mid-GEN clears everything immediately. After deassertion the block idles until a new trigger.

## Structure
- Shared package holds:
  - the S-box function;
  - the Rcon table (10 entries);
  - the mode encodings and the Nk/Nr/Ntot lookup functions;
  - NB_WORD = 32 and N_BYTES_WORD = 4.
- One sub-module, key_expand_word_step: combinational generation of a single word from w[i-1], w[i-Nk], i and the mode. The top instantiates it N_WORDS_PER_CLK times in a chain.
- The top contains the FSM, counter, register file, output rewire and error/done pulses.

## Test plan
- AES-128 (FIPS-197 A.1), key 2b7e151628aed2a6abf7158809cf4f3c with W = 1:
  - After 40 edges, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - o_done pulses exactly once.
  - Rounds 11 to 14 are zero.
- AES-192 (A.2), key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b with W = 4:
  - After 12 edges, round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 (A.3), key 603deb10…0914dff4 with W = 2:
  - After 26 edges, round 14 = fe4890d1e6188d0b046df344706c631e.
- Restart and freeze:
  - Retrigger AES-128 at GEN edge 20: no o_done at the original edge 40; done occurs 40 edges after the retrigger.
  - i_valid low for 5 cycles stretches completion by exactly 5 cycles.
- Reserved mode in READY:
  - o_key_error pulses one cycle.
  - The vector and o_keys_ready are unchanged.
- Reset mid-GEN:
  - All outputs are zero asynchronously, before the next edge.
  - A following trigger produces a correct AES-256 schedule.
